dmem_responder: RTL and testbench

- Data-memory responder: the slave end of the load/store path the processor datapath initiates.
- Accepts one word read or write request at a time over a valid/ready handshake.
- Waits a fixed, parameterised latency, then returns data or a write acknowledgement with an error flag.
- Lets the core move from an ideal combinational memory to a multi-cycle, handshaked memory.

---
 rtl/dmem_pkg.sv | 25 ++
 rtl/dmem_array.sv | 33 +++
 rtl/dmem_responder.sv | 132 +++++++++++++
 tb/tb_dmem_responder.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and defaults for the data-memory responder.
// Holds the FSM encoding, size defaults and the legal latency range.
package dmem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam int unsigned DATA_W_DEFAULT = 32;
   localparam int unsigned DEPTH_DEFAULT  = 8;
   localparam int unsigned ADDR_W_DEFAULT = 3;

   localparam int unsigned LATENCY_MIN = 1;
   localparam int unsigned LATENCY_MAX = 15;
   // Wide enough to hold LATENCY_MAX - 1.
   localparam int unsigned CNT_W       = 4;

   // Word index is out of range when any bit at or above the index width is set.
   function automatic logic addr_out_of_range(input logic [31:0] addr, input int unsigned depth);
      return addr >= 32'(depth);
   endfunction

endpackage

// File: rtl/dmem_array.sv
// DEPTH x DATA_W word storage: synchronous write, combinational read,
// whole array cleared asynchronously on reset.
module dmem_array
   import dmem_pkg::*;
#(
   parameter int unsigned DEPTH  = DEPTH_DEFAULT,
   parameter int unsigned ADDR_W = ADDR_W_DEFAULT,
   parameter int unsigned DATA_W = DATA_W_DEFAULT
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem_q [DEPTH];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   assign rdata = mem_q[raddr];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one word load/store over valid/ready, waits a
// fixed LATENCY, commits the access, then holds the response until consumed.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int unsigned DEPTH   = DEPTH_DEFAULT,
   parameter int unsigned ADDR_W  = ADDR_W_DEFAULT,
   parameter int unsigned DATA_W  = DATA_W_DEFAULT,
   parameter int unsigned LATENCY = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [31:0]       req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [DATA_W-1:0] resp_rdata,
   output logic              resp_err,
   output logic              resp_write
);

   if (LATENCY < LATENCY_MIN || LATENCY > LATENCY_MAX) begin : g_bad_latency
      $error("dmem_responder: LATENCY outside legal range");
   end
   if (DEPTH != (1 << ADDR_W)) begin : g_bad_depth
      $error("dmem_responder: DEPTH must equal 2**ADDR_W");
   end

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;

   logic               write_q;
   logic               err_q;
   logic [ADDR_W-1:0]  idx_q;
   logic [DATA_W-1:0]  wdata_q;

   logic [DATA_W-1:0]  resp_rdata_q;
   logic               resp_err_q;
   logic               resp_write_q;

   logic               accept;
   logic               commit;
   logic               mem_we;
   logic [DATA_W-1:0]  mem_rdata;

   assign accept = (state_q == IDLE) && req_valid;
   assign commit = (state_q == BUSY) && (cnt_q == '0);
   assign mem_we = commit && write_q && !err_q;

   dmem_array #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_array (
      .clk   (clk),
      .reset (reset),
      .we    (mem_we),
      .waddr (idx_q),
      .wdata (wdata_q),
      .raddr (idx_q),
      .rdata (mem_rdata)
   );

   // LATENCY==1 passes through one BUSY cycle with cnt=0, so resp_valid still
   // rises exactly LATENCY edges after acceptance.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      unique case (state_q)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               state_d = BUSY;
               cnt_d   = CNT_W'(LATENCY - 1);
            end
         end
         BUSY: begin
            if (cnt_q == '0) begin
               state_d = RESP;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         RESP: begin
            resp_valid = 1'b1;
            if (resp_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         write_q      <= 1'b0;
         err_q        <= 1'b0;
         idx_q        <= '0;
         wdata_q      <= '0;
         resp_rdata_q <= '0;
         resp_err_q   <= 1'b0;
         resp_write_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (accept) begin
            write_q <= req_write;
            err_q   <= addr_out_of_range(req_addr, DEPTH);
            idx_q   <= req_addr[ADDR_W-1:0];
            wdata_q <= req_wdata;
         end
         // Response registers only change at commit, so they hold through RESP.
         if (commit) begin
            resp_write_q <= write_q;
            resp_err_q   <= err_q;
            resp_rdata_q <= (write_q || err_q) ? '0 : mem_rdata;
         end
      end
   end

   assign resp_rdata = resp_rdata_q;
   assign resp_err   = resp_err_q;
   assign resp_write = resp_write_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed and random loads/stores on a
// LATENCY=2 instance against an array model, plus a LATENCY=1 throughput check.
module tb_dmem_responder;

   localparam int LAT = 2;

   logic        clk = 1'b0;
   logic        reset = 1'b0;

   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_write = 1'b0;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic        resp_valid;
   logic        resp_ready = 1'b0;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic        resp_write;

   logic        r1_valid = 1'b0;
   logic        r1_ready;
   logic        r1_write = 1'b0;
   logic [31:0] r1_addr = '0;
   logic [31:0] r1_wdata = '0;
   logic        r1_rvalid;
   logic        r1_rready = 1'b1;
   logic [31:0] r1_rdata;
   logic        r1_err;
   logic        r1_rwrite;

   int n_cmp = 0;
   int n_bad = 0;
   logic [31:0] model_mem [8];

   always #5 clk = ~clk;

   dmem_responder #(.LATENCY(LAT)) dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_write  (req_write),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err),
      .resp_write (resp_write)
   );

   dmem_responder #(.LATENCY(1)) dut1 (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (r1_valid),
      .req_ready  (r1_ready),
      .req_write  (r1_write),
      .req_addr   (r1_addr),
      .req_wdata  (r1_wdata),
      .resp_valid (r1_rvalid),
      .resp_ready (r1_rready),
      .resp_rdata (r1_rdata),
      .resp_err   (r1_err),
      .resp_write (r1_rwrite)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One complete transaction; hold>0 keeps resp_ready low for that many RESP cycles.
   task automatic txn(input logic w, input logic [31:0] a, input logic [31:0] d, input int hold);
      int          n;
      logic        err;
      logic [31:0] exp_rd;
      @(negedge clk);
      chk("idle_req_ready", 32'(req_ready), 32'd1);
      req_valid  = 1'b1;
      req_write  = w;
      req_addr   = a;
      req_wdata  = d;
      resp_ready = (hold == 0);
      @(negedge clk);
      req_valid = 1'b0;
      req_write = 1'($urandom_range(0, 1));
      req_addr  = $urandom;
      req_wdata = $urandom;
      n = 0;
      while (!resp_valid && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("latency", 32'(n), 32'(LAT));
      err    = (a >= 32'd8);
      exp_rd = (w || err) ? 32'd0 : model_mem[a[2:0]];
      if (w && !err) model_mem[a[2:0]] = d;
      chk("resp_valid", 32'(resp_valid), 32'd1);
      chk("resp_err", 32'(resp_err), 32'(err));
      chk("resp_write", 32'(resp_write), 32'(w));
      chk("resp_rdata", resp_rdata, exp_rd);
      chk("resp_req_ready", 32'(req_ready), 32'd0);
      for (int i = 0; i < hold; i++) begin
         req_valid = 1'b1;
         req_write = 1'b1;
         req_addr  = 32'($urandom_range(0, 7));
         req_wdata = $urandom;
         @(negedge clk);
         req_valid = 1'b0;
         chk("hold_valid", 32'(resp_valid), 32'd1);
         chk("hold_err", 32'(resp_err), 32'(err));
         chk("hold_write", 32'(resp_write), 32'(w));
         chk("hold_rdata", resp_rdata, exp_rd);
         chk("hold_req_ready", 32'(req_ready), 32'd0);
      end
      resp_ready = 1'b1;
      @(negedge clk);
      chk("done_valid", 32'(resp_valid), 32'd0);
      chk("done_req_ready", 32'(req_ready), 32'd1);
      resp_ready = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 8; i++) model_mem[i] = '0;

      #2 reset = 1'b1;
      #1;
      chk("rst_resp_valid", 32'(resp_valid), 32'd0);
      chk("rst_resp_err", 32'(resp_err), 32'd0);
      chk("rst_resp_write", 32'(resp_write), 32'd0);
      chk("rst_resp_rdata", resp_rdata, 32'd0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      chk("rst_req_ready", 32'(req_ready), 32'd1);

      // Every word reads as zero after reset.
      for (int a = 0; a < 8; a++) txn(1'b0, 32'(a), 32'd0, 0);

      txn(1'b1, 32'd3, 32'h0000_001B, 0);
      txn(1'b0, 32'd3, 32'd0, 0);

      txn(1'b0, 32'd9, 32'd0, 0);
      txn(1'b1, 32'd9, 32'hDEAD_BEEF, 0);
      txn(1'b1, 32'h8000_0001, 32'hCAFE_F00D, 0);
      txn(1'b0, 32'd1, 32'd0, 0);

      txn(1'b1, 32'd2, 32'h1234_5678, 5);
      txn(1'b0, 32'd2, 32'd0, 0);

      // Reset while a store to addr 4 is still in flight.
      @(negedge clk);
      req_valid = 1'b1;
      req_write = 1'b1;
      req_addr  = 32'd4;
      req_wdata = 32'h0000_03FF;
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      #1;
      for (int i = 0; i < 8; i++) model_mem[i] = '0;
      chk("midrst_resp_valid", 32'(resp_valid), 32'd0);
      chk("midrst_resp_err", 32'(resp_err), 32'd0);
      chk("midrst_resp_write", 32'(resp_write), 32'd0);
      chk("midrst_resp_rdata", resp_rdata, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      chk("midrst_req_ready", 32'(req_ready), 32'd1);
      txn(1'b0, 32'd4, 32'd0, 0);
      txn(1'b0, 32'd3, 32'd0, 0);

      for (int k = 0; k < 30; k++) begin
         logic [31:0] a;
         a = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 9));
         txn(1'($urandom_range(0, 1)), a, $urandom, int'($urandom_range(0, 2)));
      end

      // LATENCY=1 with resp_ready tied high: accept, busy, respond, repeat.
      @(negedge clk);
      r1_write = 1'b0;
      r1_addr  = 32'd0;
      r1_valid = 1'b1;
      for (int i = 0; i < 15; i++) begin
         if (i > 0) @(negedge clk);
         chk("l1_req_ready", 32'(r1_ready), 32'((i % 3) == 0));
         chk("l1_resp_valid", 32'(r1_rvalid), 32'((i % 3) == 2));
         if ((i % 3) == 2) begin
            chk("l1_rdata", r1_rdata, 32'd0);
            chk("l1_err", 32'(r1_err), 32'd0);
         end
      end
      r1_valid = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
